// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues pipelined imem requests and
// buffers in-order responses in a small queue that feeds the IF/ID register.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          FQ_DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        valid_o,
   output logic [31:0] PC_o,
   output logic [31:0] Inst_o
);

   localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
   localparam int CW = $clog2(FQ_DEPTH) + 1;
   localparam logic [CW:0]   DEPTH_C = (CW+1)'(FQ_DEPTH);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   logic [31:0]         fetch_pc_r;
   logic                epoch_r;
   logic [31:0]         pend_pc_r [FQ_DEPTH];
   logic [FQ_DEPTH-1:0] pend_ep_r;
   logic [PW-1:0]       pend_wp_r, pend_rp_r;
   logic [CW-1:0]       out_cnt_r;
   logic [31:0]         fq_pc_r   [FQ_DEPTH];
   logic [31:0]         fq_inst_r [FQ_DEPTH];
   logic [PW-1:0]       fq_wp_r, fq_rp_r;
   logic [CW-1:0]       fq_cnt_r;

   logic [CW:0] credit_sum_s;
   logic        req_s, issue_s, resp_s, keep_s, valid_s, pop_s;

   // Credits count both in-flight requests and queued entries, so neither FIFO can overflow.
   assign credit_sum_s = {1'b0, out_cnt_r} + {1'b0, fq_cnt_r};
   assign req_s        = rst_i & ~redirect_i & (credit_sum_s < DEPTH_C);
   assign issue_s      = req_s & imem_gnt_i;
   assign resp_s       = imem_rvalid_i & (out_cnt_r != {CW{1'b0}});
   assign keep_s       = resp_s & ~redirect_i & (pend_ep_r[pend_rp_r] == epoch_r);
   assign valid_s      = (fq_cnt_r != {CW{1'b0}});
   assign pop_s        = valid_s & ~stall_i & ~redirect_i;

   assign imem_req_o  = req_s;
   assign imem_addr_o = fetch_pc_r;
   assign valid_o     = valid_s;
   assign PC_o        = valid_s ? fq_pc_r[fq_rp_r]   : 32'h0000_0000;
   assign Inst_o      = valid_s ? fq_inst_r[fq_rp_r] : 32'h0000_0000;

   // Fetch PC and epoch; a redirect restarts fetch and retires everything in flight.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         fetch_pc_r <= RESET_PC;
         epoch_r    <= 1'b0;
      end else if (redirect_i) begin
         fetch_pc_r <= {redirect_pc_i[31:2], 2'b00};
         epoch_r    <= ~epoch_r;
      end else if (issue_s) begin
         fetch_pc_r <= fetch_pc_r + 32'd4;
         epoch_r    <= epoch_r;
      end else begin
         fetch_pc_r <= fetch_pc_r;
         epoch_r    <= epoch_r;
      end
   end

   // Pending-request FIFO of {pc, epoch}; drains even across redirects.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < FQ_DEPTH; i++) pend_pc_r[i] <= 32'h0000_0000;
         pend_ep_r <= {FQ_DEPTH{1'b0}};
         pend_wp_r <= {PW{1'b0}};
         pend_rp_r <= {PW{1'b0}};
         out_cnt_r <= {CW{1'b0}};
      end else begin
         if (issue_s) begin
            pend_pc_r[pend_wp_r] <= fetch_pc_r;
            pend_ep_r[pend_wp_r] <= epoch_r;
            pend_wp_r            <= pend_wp_r + PTR_ONE;
         end
         if (resp_s) begin
            pend_rp_r <= pend_rp_r + PTR_ONE;
         end
         out_cnt_r <= out_cnt_r + CW'(issue_s) - CW'(resp_s);
      end
   end

   // Fetch queue of {pc, inst}; only current-epoch responses enter it.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < FQ_DEPTH; i++) begin
            fq_pc_r[i]   <= 32'h0000_0000;
            fq_inst_r[i] <= 32'h0000_0000;
         end
         fq_wp_r  <= {PW{1'b0}};
         fq_rp_r  <= {PW{1'b0}};
         fq_cnt_r <= {CW{1'b0}};
      end else if (redirect_i) begin
         fq_wp_r  <= {PW{1'b0}};
         fq_rp_r  <= {PW{1'b0}};
         fq_cnt_r <= {CW{1'b0}};
      end else begin
         if (keep_s) begin
            fq_pc_r[fq_wp_r]   <= pend_pc_r[pend_rp_r];
            fq_inst_r[fq_wp_r] <= imem_rdata_i;
            fq_wp_r            <= fq_wp_r + PTR_ONE;
         end
         if (pop_s) begin
            fq_rp_r <= fq_rp_r + PTR_ONE;
         end
         fq_cnt_r <= fq_cnt_r + CW'(keep_s) - CW'(pop_s);
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: queue-based reference model plus an
// instruction memory that answers each grant after a fixed latency.
module tb_if_fetch_unit;

   localparam int DEPTH = 2;

   logic        clk_i = 1'b0;
   logic        rst_i, stall_i, redirect_i, imem_gnt_i, imem_rvalid_i;
   logic [31:0] redirect_pc_i, imem_rdata_i;
   logic        imem_req_o, valid_o;
   logic [31:0] imem_addr_o, PC_o, Inst_o;

   always #5 clk_i = ~clk_i;

   if_fetch_unit dut (
      .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .redirect_i(redirect_i),
      .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
      .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
      .valid_o(valid_o), .PC_o(PC_o), .Inst_o(Inst_o)
   );

   int n_cmp = 0;
   int n_err = 0;

   // stimulus controls, applied on the next step
   logic        s_rst = 1'b0, s_stall = 1'b0, s_redir = 1'b0, s_gnt = 1'b1;
   logic        s_rv_en = 1'b1, s_stale = 1'b0;
   logic [31:0] s_rpc = 32'h0;
   int          lat = 1;
   int          cyc = 0;

   // reference model and memory
   logic [31:0] m_pc;
   logic        m_ep;
   logic [32:0] m_pend [$];
   logic [63:0] m_fq [$];
   logic [31:0] mq_addr [$];
   int          mq_due [$];
   logic        c_rv = 1'b0, c_from_mq = 1'b0, m_req = 1'b0;
   logic [31:0] c_rdata = 32'h0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0;
      m_ep = 1'b0;
      m_pend.delete();
      m_fq.delete();
      mq_addr.delete();
      mq_due.delete();
   endtask

   // One clock: advance model on the edge, apply new inputs, compare at negedge.
   task automatic step();
      logic [32:0] hd;
      logic [63:0] h;
      bit          resp;
      @(posedge clk_i);
      if (rst_i) begin
         resp = c_rv && (m_pend.size() != 0);
         hd   = 33'h0;
         if (resp) hd = m_pend.pop_front();
         if (c_rv && c_from_mq) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
         end
         if (redirect_i) begin
            m_fq.delete();
            m_pc = {redirect_pc_i[31:2], 2'b00};
            m_ep = ~m_ep;
         end else begin
            if (m_fq.size() != 0 && !stall_i) void'(m_fq.pop_front());
            if (resp && hd[32] == m_ep) m_fq.push_back({hd[31:0], c_rdata});
            if (m_req && imem_gnt_i) begin
               m_pend.push_back({m_ep, m_pc});
               mq_addr.push_back(m_pc);
               mq_due.push_back(cyc + lat);
               m_pc = m_pc + 32'd4;
            end
         end
      end
      cyc++;
      #1;
      rst_i = s_rst;
      if (!s_rst) model_reset();
      stall_i       = s_stall;
      redirect_i    = s_redir;
      redirect_pc_i = s_rpc;
      imem_gnt_i    = s_gnt;
      if (s_stale) begin
         c_rv = 1'b1; c_rdata = 32'hDEAD_BEEF; c_from_mq = 1'b0;
      end else if (s_rv_en && mq_addr.size() != 0 && mq_due[0] <= cyc) begin
         c_rv = 1'b1; c_rdata = mq_addr[0] + 32'h100; c_from_mq = 1'b1;
      end else begin
         c_rv = 1'b0; c_rdata = 32'h0; c_from_mq = 1'b0;
      end
      imem_rvalid_i = c_rv;
      imem_rdata_i  = c_rdata;
      m_req = s_rst && !s_redir && ((m_pend.size() + m_fq.size()) < DEPTH);
      @(negedge clk_i);
      h = (m_fq.size() != 0) ? m_fq[0] : 64'h0;
      chk("req",   imem_req_o,  m_req);
      chk("addr",  imem_addr_o, m_pc);
      chk("valid", valid_o,     m_fq.size() != 0);
      chk("pc",    PC_o,        h[63:32]);
      chk("inst",  Inst_o,      h[31:0]);
   endtask

   task automatic do_reset();
      s_rst = 1'b0; step(); s_rst = 1'b1;
   endtask

   initial begin
      int          got;
      bit          seen_req, seen_val, seen_stale;
      logic [31:0] stale, addrs [2];
      int          na;
      rst_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
      imem_gnt_i = 1'b1; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
      model_reset();

      // reset held three cycles, then release
      repeat (3) begin
         step();
         chk("rst_req", imem_req_o, 1'b0);
         chk("rst_valid", valid_o, 1'b0);
         chk("rst_pc", PC_o, 32'h0);
         chk("rst_inst", Inst_o, 32'h0);
      end
      s_rst = 1'b1;
      step();
      chk("first_req", imem_req_o, 1'b1);
      chk("first_addr", imem_addr_o, 32'h0);

      // streaming: delivered heads must be 0,4,8,12 with inst = pc+0x100
      got = 0;
      for (int i = 0; i < 30 && got < 4; i++) begin
         step();
         if (valid_o) begin
            chk("stream_pc", PC_o, 32'(got * 4));
            chk("stream_inst", Inst_o, 32'(got * 4) + 32'h100);
            got++;
         end
      end
      chk("stream_count", 32'(got), 32'd4);

      // stall backpressure from a fresh start
      do_reset();
      s_stall = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (k == 6) s_stall = 1'b0;
         step();
         if (k >= 2 && k <= 5) begin
            chk("stall_pc", PC_o, 32'h0);
            chk("stall_inst", Inst_o, 32'h100);
         end
         if (k >= 2 && k <= 6) chk("stall_req", imem_req_o, 1'b0);
         if (k == 7) begin
            chk("resume_req", imem_req_o, 1'b1);
            chk("resume_addr", imem_addr_o, 32'h8);
         end
      end

      // redirect with two requests in flight
      do_reset();
      s_rv_en = 1'b0;
      step(); step();
      s_redir = 1'b1; s_rpc = 32'h0000_0043;
      step();
      chk("redir_req", imem_req_o, 1'b0);
      s_redir = 1'b0; s_rv_en = 1'b1;
      seen_req = 1'b0; seen_val = 1'b0;
      for (int i = 0; i < 20 && !(seen_req && seen_val); i++) begin
         step();
         if (!seen_req && imem_req_o) begin
            chk("redir_addr", imem_addr_o, 32'h40);
            seen_req = 1'b1;
         end
         if (!seen_val && valid_o) begin
            chk("redir_pc", PC_o, 32'h40);
            chk("redir_inst", Inst_o, 32'h140);
            seen_val = 1'b1;
         end
      end
      chk("redir_seen", {30'h0, seen_req, seen_val}, 32'h3);

      // redirect, stall and rvalid in the same cycle
      s_rv_en = 1'b0; s_stall = 1'b1;
      for (int i = 0; i < 10 && m_pend.size() < 2; i++) step();
      s_rv_en = 1'b1;
      step();
      s_redir = 1'b1; s_rpc = 32'h0000_0200;
      step();
      stale = c_rdata;
      s_redir = 1'b0; s_stall = 1'b0;
      step();
      chk("rsr_valid", valid_o, 1'b0);
      chk("rsr_pc", PC_o, 32'h0);
      chk("rsr_inst", Inst_o, 32'h0);
      seen_stale = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (valid_o && Inst_o == stale) seen_stale = 1'b1;
      end
      chk("rsr_stale_hidden", seen_stale, 1'b0);

      // wrap of the fetch PC
      s_redir = 1'b1; s_rpc = 32'hFFFF_FFFC;
      step();
      s_redir = 1'b0;
      na = 0;
      for (int i = 0; i < 20 && na < 2; i++) begin
         step();
         if (imem_req_o) begin
            addrs[na] = imem_addr_o;
            na++;
         end
      end
      chk("wrap_n", 32'(na), 32'd2);
      chk("wrap_a0", addrs[0], 32'hFFFF_FFFC);
      chk("wrap_a1", addrs[1], 32'h0);

      // mid-operation reset with two outstanding, stale rvalid afterwards
      s_rv_en = 1'b0;
      for (int i = 0; i < 10 && m_pend.size() < 2; i++) step();
      s_rst = 1'b0; s_stale = 1'b1;
      step();
      chk("mrst_req", imem_req_o, 1'b0);
      chk("mrst_addr", imem_addr_o, 32'h0);
      chk("mrst_valid", valid_o, 1'b0);
      chk("mrst_pc", PC_o, 32'h0);
      chk("mrst_inst", Inst_o, 32'h0);
      step();
      s_rst = 1'b1; s_rv_en = 1'b1;
      step();
      chk("mrst_req1", imem_req_o, 1'b1);
      chk("mrst_addr1", imem_addr_o, 32'h0);
      s_stale = 1'b0;
      seen_val = 1'b0;
      for (int i = 0; i < 20 && !seen_val; i++) begin
         step();
         if (valid_o) begin
            chk("mrst_pc1", PC_o, 32'h0);
            chk("mrst_inst1", Inst_o, 32'h100);
            seen_val = 1'b1;
         end
      end
      chk("mrst_seen", seen_val, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
